// File: rtl/video_src_switch.sv
// N-channel video source selector for the frame DMA path.
// Switches only on frame starts and blanks on vsync loss.
module video_src_switch #(
  parameter int                NUM_CH       = 4,
  parameter int                DATA_W       = 16,
  parameter int                DEFAULT_CH   = 0,
  parameter bit                VS_POL       = 1'b1,
  parameter int                LOSS_TIMEOUT = 2**20,
  parameter logic [DATA_W-1:0] FILL         = '0,
  localparam int               CH_W         = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_W-1:0]          sel_req,
  input  logic                     sel_valid,
  input  logic [NUM_CH-1:0]        ch_vs,
  input  logic [NUM_CH-1:0]        ch_de,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_vs,
  output logic                     out_de,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          cur_sel,
  output logic                     switching,
  output logic                     sel_err,
  output logic [NUM_CH-1:0]        ch_alive,
  output logic [15:0]              frame_cnt
);

  localparam int CNT_W = $clog2(LOSS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO  = CNT_W'(LOSS_TIMEOUT);
  localparam logic [CH_W:0]    NCH = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  DEF = CH_W'(DEFAULT_CH);

  typedef enum logic [1:0] {
    PASS,
    WAIT_NEW,
    BLANK
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CH_W-1:0]   cur_n;
  logic [CH_W-1:0]   tgt;
  logic [CH_W-1:0]   tgt_n;
  logic              pend;
  logic              pend_n;
  logic [NUM_CH-1:0] vs_act;
  logic [NUM_CH-1:0] vs_q;
  logic [NUM_CH-1:0] fs;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              req_bad;
  logic              req_ok;
  logic              fsc;
  logic              dead;
  logic              sel_vs;
  logic              sel_de;
  logic [DATA_W-1:0] sel_data;

  assign vs_act = VS_POL ? ch_vs : ~ch_vs;

  // Edge history keeps tracking through reset so no false edge follows it
  always_ff @(posedge clk) begin
    vs_q <= vs_act;
  end

  assign fs       = vs_act & ~vs_q;
  assign req_bad  = sel_valid && ({1'b0, sel_req} >= NCH);
  assign req_ok   = sel_valid && !req_bad;
  assign fsc      = fs[cur_sel];
  assign dead     = !ch_alive[cur_sel];
  assign sel_vs   = ch_vs[cur_sel];
  assign sel_de   = ch_de[cur_sel];
  assign sel_data = ch_data[cur_sel*DATA_W +: DATA_W];

  always_comb begin
    state_n = state;
    cur_n   = cur_sel;
    pend_n  = pend;
    tgt_n   = tgt;
    unique case (state)
      PASS: begin
        if (req_ok) begin
          pend_n = (sel_req != cur_sel);
          tgt_n  = sel_req;
        end
        if (fsc && pend_n) begin
          state_n = WAIT_NEW;
          cur_n   = tgt_n;
          pend_n  = 1'b0;
        end else if (dead && !fsc) begin
          state_n = BLANK;
          pend_n  = 1'b0;
        end
      end
      WAIT_NEW: begin
        if (req_ok) begin
          cur_n = sel_req;
        end else if (fsc) begin
          state_n = PASS;
        end else if (dead) begin
          state_n = BLANK;
        end
      end
      BLANK: begin
        if (req_ok) begin
          cur_n   = sel_req;
          state_n = WAIT_NEW;
        end else if (fsc) begin
          state_n = PASS;
        end
      end
      default: state_n = WAIT_NEW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_NEW;
      cur_sel   <= DEF;
      tgt       <= DEF;
      pend      <= 1'b0;
      out_vs    <= ~VS_POL;
      out_de    <= 1'b0;
      out_data  <= '0;
      switching <= 1'b1;
      sel_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      cur_sel   <= cur_n;
      tgt       <= tgt_n;
      pend      <= pend_n;
      sel_err   <= req_bad;
      switching <= (state_n != PASS) || pend_n;
      // Forward only when the decision for this cycle lands in PASS
      if (state_n == PASS) begin
        out_vs   <= sel_vs;
        out_de   <= sel_de;
        out_data <= sel_data;
      end else begin
        out_vs   <= ~VS_POL;
        out_de   <= 1'b0;
        out_data <= FILL;
      end
      if (state_n == PASS && fsc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_alive <= '1;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (fs[k]) begin
          cnt[k]      <= '0;
          ch_alive[k] <= 1'b1;
        end else if (cnt[k] != TO) begin
          cnt[k] <= cnt[k] + 1'b1;
          if (cnt[k] == TO - 1'b1) begin
            ch_alive[k] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
